// File: rtl/exp6_pkg.sv
// Shared state encoding for the experiment-6 control unit.
// The 4-bit codes double as the debug display value, so they are fixed.
package exp6_pkg;

  typedef enum logic [3:0] {
    IDLE             = 4'h0,
    PREPARACAO       = 4'h1,
    INICIO           = 4'h2,
    ESPERA           = 4'h3,
    REGISTRA         = 4'h4,
    COMPARACAO       = 4'h5,
    PROXIMA_JOGADA   = 4'h6,
    ULTIMA_JOGADA    = 4'h7,
    PROXIMA_RODADA   = 4'h8,
    FIM_A            = 4'hA,
    ATUALIZA_MEMORIA = 4'hB,
    FIM_T            = 4'hD,
    FIM_E            = 4'hE
  } estado_t;

endpackage

// File: rtl/exp6_unidade_controle.sv
// Moore control unit for the experiment-6 game datapath: sequences
// presentation, play capture, comparison and the win/error/timeout endings.
module exp6_unidade_controle
  import exp6_pkg::*;
#(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraCR,
  output logic       zeraE,
  output logic       contaCR,
  output logic       contaE,
  output logic       limpaRC,
  output logic       registraRC,
  output logic       zeraLeds,
  output logic       registraLeds,
  output logic       contaT,
  output logic       led_selector,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t estado_atual;
  estado_t proximo_estado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_atual <= IDLE;
    else       estado_atual <= proximo_estado;
  end

  // Unused codes (9, C, F) fall into the default arm and recover to idle.
  always_comb begin
    proximo_estado = IDLE;
    case (estado_atual)
      IDLE:             proximo_estado = jogar ? PREPARACAO : IDLE;
      PREPARACAO:       proximo_estado = INICIO;
      INICIO:           proximo_estado = ESPERA;
      ESPERA: begin
        if (timeout && TIMEOUT_EN) proximo_estado = FIM_T;
        else if (jogada_feita)     proximo_estado = REGISTRA;
        else                       proximo_estado = ESPERA;
      end
      REGISTRA:         proximo_estado = ATUALIZA_MEMORIA;
      ATUALIZA_MEMORIA: proximo_estado = COMPARACAO;
      COMPARACAO: begin
        if (!jogada_correta)          proximo_estado = FIM_E;
        else if (enderecoIgualRodada) proximo_estado = ULTIMA_JOGADA;
        else                          proximo_estado = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA:   proximo_estado = ESPERA;
      ULTIMA_JOGADA:    proximo_estado = fimL ? FIM_A : PROXIMA_RODADA;
      PROXIMA_RODADA:   proximo_estado = INICIO;
      FIM_A:            proximo_estado = jogar ? PREPARACAO : FIM_A;
      FIM_E:            proximo_estado = jogar ? PREPARACAO : FIM_E;
      FIM_T:            proximo_estado = jogar ? PREPARACAO : FIM_T;
      default:          proximo_estado = IDLE;
    endcase
  end

  always_comb begin
    zeraCR       = 1'b0;
    zeraE        = 1'b0;
    contaCR      = 1'b0;
    contaE       = 1'b0;
    limpaRC      = 1'b0;
    registraRC   = 1'b0;
    zeraLeds     = 1'b0;
    registraLeds = 1'b0;
    contaT       = 1'b0;
    led_selector = 1'b0;
    pronto       = 1'b0;
    ganhou       = 1'b0;
    perdeu       = 1'b0;
    db_timeout   = 1'b0;
    db_estado    = estado_atual;
    case (estado_atual)
      IDLE: begin
        zeraCR   = 1'b1;
        zeraE    = 1'b1;
        limpaRC  = 1'b1;
        zeraLeds = 1'b1;
      end
      PREPARACAO: begin
        zeraCR       = 1'b1;
        zeraE        = 1'b1;
        limpaRC      = 1'b1;
        zeraLeds     = 1'b1;
        led_selector = 1'b1;
      end
      INICIO: begin
        zeraE        = 1'b1;
        registraLeds = 1'b1;
        led_selector = 1'b1;
      end
      ESPERA:         contaT = 1'b1;
      REGISTRA: begin
        registraRC   = 1'b1;
        registraLeds = 1'b1;
      end
      PROXIMA_JOGADA: contaE = 1'b1;
      PROXIMA_RODADA: begin
        contaCR      = 1'b1;
        led_selector = 1'b1;
      end
      FIM_A: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FIM_E: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      FIM_T: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Bench for exp6_unidade_controle: two instances (timeout honoured / ignored)
// checked every cycle against a table-driven model plus literal sequence checks.
module tb_exp6_unidade_controle;
  import exp6_pkg::*;

  logic clock = 1'b0;
  logic reset, jogar, jogada_feita, jogada_correta, enderecoIgualRodada, fimL, timeout;

  logic a_zeraCR, a_zeraE, a_contaCR, a_contaE, a_limpaRC, a_registraRC, a_zeraLeds;
  logic a_registraLeds, a_contaT, a_led_selector, a_pronto, a_ganhou, a_perdeu, a_db_timeout;
  logic [3:0] a_db_estado;
  logic b_zeraCR, b_zeraE, b_contaCR, b_contaE, b_limpaRC, b_registraRC, b_zeraLeds;
  logic b_registraLeds, b_contaT, b_led_selector, b_pronto, b_ganhou, b_perdeu, b_db_timeout;
  logic [3:0] b_db_estado;

  int assertions = 0;
  int failures   = 0;
  int model_a    = 0;
  int model_b    = 0;
  bit inject_f   = 1'b0;

  exp6_unidade_controle #(.TIMEOUT_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset), .jogar(jogar), .jogada_feita(jogada_feita),
    .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
    .fimL(fimL), .timeout(timeout),
    .zeraCR(a_zeraCR), .zeraE(a_zeraE), .contaCR(a_contaCR), .contaE(a_contaE),
    .limpaRC(a_limpaRC), .registraRC(a_registraRC), .zeraLeds(a_zeraLeds),
    .registraLeds(a_registraLeds), .contaT(a_contaT), .led_selector(a_led_selector),
    .pronto(a_pronto), .ganhou(a_ganhou), .perdeu(a_perdeu), .db_timeout(a_db_timeout),
    .db_estado(a_db_estado)
  );

  exp6_unidade_controle #(.TIMEOUT_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .jogar(jogar), .jogada_feita(jogada_feita),
    .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
    .fimL(fimL), .timeout(timeout),
    .zeraCR(b_zeraCR), .zeraE(b_zeraE), .contaCR(b_contaCR), .contaE(b_contaE),
    .limpaRC(b_limpaRC), .registraRC(b_registraRC), .zeraLeds(b_zeraLeds),
    .registraLeds(b_registraLeds), .contaT(b_contaT), .led_selector(b_led_selector),
    .pronto(b_pronto), .ganhou(b_ganhou), .perdeu(b_perdeu), .db_timeout(b_db_timeout),
    .db_estado(b_db_estado)
  );

  always #5 clock = ~clock;

  wire [13:0] a_vec = {a_zeraCR, a_zeraE, a_contaCR, a_contaE, a_limpaRC, a_registraRC,
                       a_zeraLeds, a_registraLeds, a_contaT, a_led_selector,
                       a_pronto, a_ganhou, a_perdeu, a_db_timeout};
  wire [13:0] b_vec = {b_zeraCR, b_zeraE, b_contaCR, b_contaE, b_limpaRC, b_registraRC,
                       b_zeraLeds, b_registraLeds, b_contaT, b_led_selector,
                       b_pronto, b_ganhou, b_perdeu, b_db_timeout};

  // Expected strobes from the membership lists of each output.
  function automatic logic [13:0] exp_outs(input int s);
    logic [13:0] v;
    v[13] = (s == 0 || s == 1);
    v[12] = (s == 0 || s == 1 || s == 2);
    v[11] = (s == 8);
    v[10] = (s == 6);
    v[9]  = (s == 0 || s == 1);
    v[8]  = (s == 4);
    v[7]  = (s == 0 || s == 1);
    v[6]  = (s == 4 || s == 2);
    v[5]  = (s == 3);
    v[4]  = (s == 1 || s == 2 || s == 8);
    v[3]  = (s == 10 || s == 13 || s == 14);
    v[2]  = (s == 10);
    v[1]  = (s == 13 || s == 14);
    v[0]  = (s == 13);
    return v;
  endfunction

  function automatic int next_code(input int s, input bit jg, input bit jf, input bit jc,
                                   input bit eir, input bit fl, input bit to, input bit ten);
    int n;
    n = 0;
    if (s == 0 || s == 10 || s == 13 || s == 14) n = jg ? 1 : s;
    else if (s == 1)  n = 2;
    else if (s == 2)  n = 3;
    else if (s == 3)  n = (to && ten) ? 13 : (jf ? 4 : 3);
    else if (s == 4)  n = 11;
    else if (s == 11) n = 5;
    else if (s == 5)  n = !jc ? 14 : (eir ? 7 : 6);
    else if (s == 6)  n = 3;
    else if (s == 7)  n = fl ? 10 : 8;
    else if (s == 8)  n = 2;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit jg, input bit jf, input bit jc,
                               input bit eir, input bit fl, input bit to);
    @(negedge clock);
    jogar = jg; jogada_feita = jf; jogada_correta = jc;
    enderecoIgualRodada = eir; fimL = fl; timeout = to;
  endtask

  task automatic step(input bit jg, input bit jf, input bit jc, input bit eir,
                      input bit fl, input bit to, input int ea, input int eb);
    applyStimulus(jg, jf, jc, eir, fl, to);
    @(posedge clock);
    #2;
    checkOutput("seq_a", {28'd0, a_db_estado}, ea);
    checkOutput("seq_b", {28'd0, b_db_estado}, eb);
  endtask

  // Model update and per-cycle comparison of both instances.
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        model_a = 0;
        model_b = 0;
      end else begin
        if (inject_f) begin
          model_a  = 15;
          inject_f = 1'b0;
        end
        model_a = next_code(model_a, jogar, jogada_feita, jogada_correta,
                            enderecoIgualRodada, fimL, timeout, 1'b1);
        model_b = next_code(model_b, jogar, jogada_feita, jogada_correta,
                            enderecoIgualRodada, fimL, timeout, 1'b0);
      end
      #1;
      checkOutput("model_estado_a", {28'd0, a_db_estado}, model_a);
      checkOutput("model_outs_a", {18'd0, a_vec}, {18'd0, exp_outs(model_a)});
      checkOutput("model_estado_b", {28'd0, b_db_estado}, model_b);
      checkOutput("model_outs_b", {18'd0, b_vec}, {18'd0, exp_outs(model_b)});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; jogar = 1'b0; jogada_feita = 1'b0; jogada_correta = 1'b0;
    enderecoIgualRodada = 1'b0; fimL = 1'b0; timeout = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    checkOutput("reset_estado", {28'd0, a_db_estado}, 32'd0);
    checkOutput("reset_zeraCR", {31'd0, a_zeraCR}, 32'd1);
    checkOutput("reset_zeraE", {31'd0, a_zeraE}, 32'd1);
    checkOutput("reset_limpaRC", {31'd0, a_limpaRC}, 32'd1);
    checkOutput("reset_zeraLeds", {31'd0, a_zeraLeds}, 32'd1);
    checkOutput("reset_others", {18'd0, a_vec & 14'b00_1101_0111_1111}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step(0,0,0,0,0,0, 0,0);

    // Round 1: start, one correct final play of the round, advance
    step(1,0,0,0,0,0, 1,1);
    step(0,0,0,0,0,0, 2,2);
    step(0,0,0,0,0,0, 3,3);
    step(0,1,1,1,0,0, 4,4);
    step(0,0,1,1,0,0, 11,11);
    step(0,0,1,1,0,0, 5,5);
    step(0,0,1,1,0,0, 7,7);
    step(0,0,1,1,0,0, 8,8);
    checkOutput("contaCR_on", {31'd0, a_contaCR}, 32'd1);
    step(0,0,1,1,0,0, 2,2);
    checkOutput("contaCR_off", {31'd0, a_contaCR}, 32'd0);
    step(0,0,0,0,0,0, 3,3);

    // Round 2: intermediate correct play, then a wrong one
    step(0,1,1,0,0,0, 4,4);
    step(0,0,1,0,0,0, 11,11);
    step(0,0,1,0,0,0, 5,5);
    step(0,0,1,0,0,0, 6,6);
    checkOutput("contaE_on", {31'd0, a_contaE}, 32'd1);
    step(0,0,0,0,0,0, 3,3);
    checkOutput("contaE_off", {31'd0, a_contaE}, 32'd0);
    step(0,1,0,0,0,0, 4,4);
    step(0,0,0,0,0,0, 11,11);
    step(0,0,0,0,0,0, 5,5);
    step(0,0,0,0,0,0, 14,14);
    checkOutput("erro_perdeu", {31'd0, a_perdeu}, 32'd1);
    checkOutput("erro_pronto", {31'd0, a_pronto}, 32'd1);
    step(0,0,0,0,0,0, 14,14);
    step(1,0,0,0,0,0, 1,1);
    step(0,0,0,0,0,0, 2,2);
    step(0,0,0,0,0,0, 3,3);

    // Timeout and play together: instance a times out, b registers the play
    step(0,1,1,1,1,1, 13,4);
    checkOutput("timeout_a", {31'd0, a_db_timeout}, 32'd1);
    checkOutput("timeout_b", {31'd0, b_db_timeout}, 32'd0);
    step(0,0,1,1,1,0, 13,11);
    step(0,0,1,1,1,0, 13,5);
    step(0,0,1,1,1,0, 13,7);
    step(0,0,1,1,1,0, 13,10);
    step(1,0,0,0,0,0, 1,1);
    step(0,0,0,0,0,0, 2,2);
    step(0,0,0,0,0,0, 3,3);

    // Last play of the last round: win, then restart
    step(0,1,1,1,1,0, 4,4);
    step(0,0,1,1,1,0, 11,11);
    step(0,0,1,1,1,0, 5,5);
    step(0,0,1,1,1,0, 7,7);
    step(0,0,1,1,1,0, 10,10);
    checkOutput("win_ganhou", {31'd0, a_ganhou}, 32'd1);
    step(1,0,0,0,0,0, 1,1);
    step(0,0,0,0,0,0, 2,2);
    step(0,0,0,0,0,0, 3,3);

    // Asynchronous reset in the middle of espera
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_a", {28'd0, a_db_estado}, 32'd0);
    checkOutput("async_reset_b", {28'd0, b_db_estado}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step(0,0,0,0,0,0, 0,0);

    // Unused code F recovers to idle after one clock
    @(negedge clock);
    force dut_a.estado_atual = estado_t'(4'hF);
    inject_f = 1'b1;
    #1;
    checkOutput("forced_code", {28'd0, a_db_estado}, 32'hF);
    release dut_a.estado_atual;
    @(posedge clock);
    #2;
    checkOutput("recover_f", {28'd0, a_db_estado}, 32'd0);
    step(0,0,0,0,0,0, 0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/exp6_unidade_controle.md
# exp6_unidade_controle

Moore control unit that sequences the experiment-6 game datapath (`exp6_fluxo_dados`) through preparation, LED presentation, play capture, comparison, round advance and the three end conditions (win, error, timeout). It drives every datapath control strobe from its state register and consumes the datapath status flags. It sits beside the datapath inside the top-level circuit and exports its state code for the debug displays.

## Interface
- `TIMEOUT_EN`, default 1; when 1, `timeout` is honoured in `espera`; when 0, `timeout` is ignored.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces state `idle`.
- `jogar` in 1: start/restart request, level-sampled.
- `jogada_feita` in 1: one-cycle pulse from the datapath edge detector.
- `jogada_correta` in 1: the registered play equals the memory word.
- `enderecoIgualRodada` in 1: the play counter equals the round counter.
- `fimL` in 1: the round counter is at its last value.
- `timeout` in 1: the play timer has expired.
- `zeraCR`, `zeraE`, `contaCR`, `contaE`, `limpaRC`, `registraRC`, `zeraLeds`, `registraLeds`, `contaT`, `led_selector` out 1 each: datapath strobes.
- `pronto` out 1: high in any end state.
- `ganhou` out 1: high in `fim_A`.
- `perdeu` out 1: high in `fim_E` or `fim_T`.
- `db_timeout` out 1: high in `fim_T`.
- `db_estado` out 4: current state code.

## Operation
State codes are 4 bits:
- idle 0, preparacao 1, inicio 2, espera 3, registra 4, comparacao 5, proxima_jogada 6, ultima_jogada 7, proxima_rodada 8, fim_A A, atualiza_memoria B, fim_T D, fim_E E.
- Codes 9, C and F are unused and go to `idle` on the next clock.

Transitions:
- idle→preparacao if `jogar`, else hold.
- preparacao→inicio→espera, unconditional.
- espera: → fim_T if `timeout && TIMEOUT_EN`; else → registra if `jogada_feita`; else hold. Timeout wins over a simultaneous play.
- registra→atualiza_memoria→comparacao, unconditional.
- comparacao: → fim_E if `!jogada_correta`; else → ultima_jogada if `enderecoIgualRodada`; else → proxima_jogada.
- proxima_jogada→espera.
- ultima_jogada: → fim_A if `fimL`, else → proxima_rodada.
- proxima_rodada→inicio.
- fim_A, fim_E, fim_T: → preparacao if `jogar`, else hold.

Output decode (pure function of state, Moore):
- `zeraCR`, `limpaRC`, `zeraLeds`: high in idle and preparacao.
- `zeraE`: high in idle, preparacao and inicio.
- `registraRC`: high in registra.
- `registraLeds`: high in registra and inicio.
- `contaCR`: high in proxima_rodada.
- `contaE`: high in proxima_jogada.
- `contaT`: high in espera.
- `led_selector`: high in preparacao, inicio and proxima_rodada.
- `db_estado` equals the state code.

## Timing
- Reset (asynchronous) gives state idle, so:
  - `zeraCR`, `zeraE`, `limpaRC`, `zeraLeds` = 1;
  - all other strobes and status outputs = 0;
  - `db_estado` = 0.
- One transition per rising edge. Outputs change only after the edge that enters a state, with no combinational path from inputs to outputs.
- `jogada_feita` seen in espera at edge N gives:
  - registra during cycle N+1;
  - comparacao decided at edge N+3;
  - the end state or next state visible in cycle N+4.
- Start latency: `jogar` sampled at edge N gives inicio at N+2 and espera at N+3.
- `jogar` held high across an end state restarts exactly once per pass (end→preparacao). Holding it longer has no effect outside idle and the end states.
- Inputs are assumed synchronous to `clock`. `jogada_feita` outside espera is ignored.
- Reset asserted mid-game returns the FSM to idle immediately. The datapath is cleared on the following cycles by the idle strobes.

## Structure
- Shared package `exp6_pkg` holds the 4-bit state constants. The testbench and the top level use these for `db_estado` decoding.
- Split into a state register plus two combinational processes (next-state and output decode). No sub-module is needed.

## Test plan
- Reset with `jogar=0` → `db_estado=0`; `zeraCR=zeraE=limpaRC=zeraLeds=1`; all others 0.
- `jogar` for 1 cycle, then `jogada_feita` pulse with `jogada_correta=1`, `enderecoIgualRodada=1`, `fimL=0` → state sequence 1,2,3,4,B,5,7,8,2; `contaCR` high for exactly 1 cycle.
- Round 2, first play correct with `enderecoIgualRodada=0` → 5→6→3 with a single-cycle `contaE`. Second play with `jogada_correta=0` → E; `perdeu=1`, `pronto=1`.
- In espera, `timeout=1` and `jogada_feita=1` in the same cycle → D; `db_timeout=1`. Repeat with `TIMEOUT_EN=0` → 4.
- Correct last play with `fimL=1` → A, `ganhou=1`. Then `jogar=1` → 1 on the next edge.
- Assert `reset` asynchronously mid-espera → `db_estado=0` before the next edge. Force code F → 0 after 1 clock.
